// File: rtl/frequency_decoder.sv
// Measures the period of FREQ_IN in CLK cycles and averages 2^AVG_LOG2 periods.
// Rejects edges closer than MIN_PERIOD and flags loss of signal after TIMEOUT cycles.
module frequency_decoder #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned LOW_FREQ   = 1_000,
  parameter int unsigned HIGH_FREQ  = 20_000_000,
  parameter int unsigned AVG_LOG2   = 2,
  localparam int unsigned MAX_PERIOD  = CLOCK_FREQ / LOW_FREQ,
  localparam int unsigned MIN_PERIOD  = (CLOCK_FREQ / HIGH_FREQ > 2) ? CLOCK_FREQ / HIGH_FREQ : 2,
  localparam int unsigned TIMEOUT     = 2 * MAX_PERIOD,
  localparam int unsigned PERIOD_BITS = $clog2(TIMEOUT + 1)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   FREQ_IN,
  output logic [PERIOD_BITS-1:0] PERIOD_OUT,
  output logic                   PERIOD_VALID,
  output logic                   NO_SIGNAL
);

  localparam int unsigned ACC_BITS = PERIOD_BITS + AVG_LOG2;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t                 state, state_d;
  logic                   s1, s2, s3;
  logic                   rise, accept, timeout;
  logic [PERIOD_BITS-1:0] cnt, cnt_d, cnt_inc;
  logic [ACC_BITS-1:0]    acc, acc_d, acc_sum;
  logic [AVG_LOG2-1:0]    n, n_d;
  logic [PERIOD_BITS-1:0] period_d;
  logic                   valid_d, no_signal_d;

  // Two-flop synchronizer plus a history flop for rising-edge detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= FREQ_IN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise    = s2 & ~s3;
  assign timeout = (cnt == PERIOD_BITS'(TIMEOUT));
  assign cnt_inc = timeout ? cnt : cnt + 1'b1;
  assign accept  = rise && (cnt >= PERIOD_BITS'(MIN_PERIOD));
  assign acc_sum = acc + ACC_BITS'(cnt);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      cnt          <= '0;
      acc          <= '0;
      n            <= '0;
      PERIOD_OUT   <= '0;
      PERIOD_VALID <= 1'b0;
      NO_SIGNAL    <= 1'b1;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      acc          <= acc_d;
      n            <= n_d;
      PERIOD_OUT   <= period_d;
      PERIOD_VALID <= valid_d;
      NO_SIGNAL    <= no_signal_d;
    end
  end

  // An accepted edge takes priority over a simultaneous timeout
  always_comb begin
    state_d     = state;
    cnt_d       = cnt_inc;
    acc_d       = acc;
    n_d         = n;
    period_d    = PERIOD_OUT;
    valid_d     = 1'b0;
    no_signal_d = NO_SIGNAL;
    case (state)
      IDLE: begin
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = PERIOD_BITS'(1);
          acc_d   = '0;
          n_d     = '0;
        end
      end
      MEASURE: begin
        if (accept) begin
          cnt_d = PERIOD_BITS'(1);
          if (n == {AVG_LOG2{1'b1}}) begin
            period_d    = PERIOD_BITS'(acc_sum >> AVG_LOG2);
            valid_d     = 1'b1;
            no_signal_d = 1'b0;
            acc_d       = '0;
            n_d         = '0;
          end else begin
            acc_d = acc_sum;
            n_d   = n + 1'b1;
          end
        end else if (timeout) begin
          state_d     = IDLE;
          no_signal_d = 1'b1;
          period_d    = '0;
          acc_d       = '0;
          n_d         = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
